// File: rtl/lut_neuron_loader.sv
// Truth-table neuron: a framed config stream fills a 2^IN_BITS-entry LUT,
// then lookups on M0 return the stored entry one cycle later on M1.
module lut_neuron_loader #(
  parameter int IN_BITS  = 8,
  parameter int OUT_BITS = 1,
  parameter int CFG_W    = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [CFG_W-1:0]    cfg_data,
  input  logic                cfg_last,
  input  logic                err_clr,
  input  logic [IN_BITS-1:0]  M0,
  input  logic                in_valid,
  output logic [OUT_BITS-1:0] M1,
  output logic                out_valid,
  output logic                table_valid,
  output logic                cfg_err
);

  localparam int DEPTH  = 2 ** IN_BITS;
  localparam int EPB    = CFG_W / OUT_BITS;
  localparam int NBEATS = DEPTH / EPB;
  localparam int CW     = (NBEATS > 1) ? $clog2(NBEATS) : 1;

  typedef enum logic [1:0] {EMPTY, LOAD, ACTIVE} state_t;

  state_t              state;
  logic [CW-1:0]       cnt;
  logic [CW-1:0]       bidx;
  logic                acc, is_final, ferr, wr;
  logic [OUT_BITS-1:0] mem [DEPTH];

  // Never back-pressures; only gated off while reset is held.
  assign cfg_ready = rst_n;

  always_comb begin
    acc      = cfg_valid & cfg_ready;
    bidx     = (state == LOAD) ? cnt : '0;
    is_final = (state == LOAD) ? (cnt == CW'(NBEATS - 1)) : (NBEATS == 1);
    ferr     = acc & (cfg_last != is_final);
    wr       = acc & ~ferr;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= EMPTY;
      cnt         <= '0;
      table_valid <= 1'b0;
      cfg_err     <= 1'b0;
    end else begin
      // A new error in the same cycle as err_clr keeps the flag set.
      if (ferr)         cfg_err <= 1'b1;
      else if (err_clr) cfg_err <= 1'b0;

      if (ferr) begin
        state       <= EMPTY;
        cnt         <= '0;
        table_valid <= 1'b0;
      end else if (acc) begin
        if (is_final) begin
          state       <= ACTIVE;
          cnt         <= '0;
          table_valid <= 1'b1;
        end else begin
          state       <= LOAD;
          cnt         <= bidx + CW'(1);
          table_valid <= 1'b0;
        end
      end
    end
  end

  // Unreset LUT storage; a beat lands EPB entries at once.
  always_ff @(posedge clk) begin
    if (wr)
      for (int j = 0; j < EPB; j++)
        mem[IN_BITS'(int'(bidx) * EPB + j)] <= cfg_data[j*OUT_BITS +: OUT_BITS];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      M1        <= '0;
    end else begin
      out_valid <= in_valid & table_valid;
      if (in_valid & table_valid) M1 <= mem[M0];
    end
  end

endmodule

// File: tb/tb_lut_neuron_loader.sv
// Bench for lut_neuron_loader: directed framing/lookup sequences plus a
// randomized run, all checked every cycle against a frame-level model.
module tb_lut_neuron_loader;

  localparam int NB  = 16;
  localparam int EPB = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cfg_valid = 1'b0;
  logic        cfg_ready;
  logic [15:0] cfg_data = '0;
  logic        cfg_last = 1'b0;
  logic        err_clr = 1'b0;
  logic [7:0]  M0 = '0;
  logic        in_valid = 1'b0;
  logic [0:0]  M1;
  logic        out_valid, table_valid, cfg_err;

  lut_neuron_loader dut (
    .clk(clk), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_data(cfg_data), .cfg_last(cfg_last), .err_clr(err_clr), .M0(M0),
    .in_valid(in_valid), .M1(M1), .out_valid(out_valid),
    .table_valid(table_valid), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  // Reference model: table as a flat bit array, load progress as a beat count.
  bit mtab [256];
  int mframe;
  bit mtv, merr, mov, mm1;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [7:0] m0;
    logic       exp_m1;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic step();
    bit fin, e;
    @(posedge clk);
    if (!rst_n) begin
      mframe = 0; mtv = 0; merr = 0; mov = 0; mm1 = 0;
    end else begin
      e   = 0;
      mov = in_valid && mtv;
      if (mov) mm1 = mtab[M0];
      if (cfg_valid) begin
        fin = (mframe == NB - 1);
        if (cfg_last != fin) begin
          e = 1; merr = 1; mtv = 0; mframe = 0;
        end else begin
          for (int j = 0; j < EPB; j++) mtab[mframe*EPB + j] = cfg_data[j];
          if (fin) begin mtv = 1; mframe = 0; end
          else begin mtv = 0; mframe++; end
        end
      end
      if (err_clr && !e) merr = 0;
    end
    #1;
    chk("out_valid", out_valid, mov);
    chk("M1", M1, mm1);
    chk("table_valid", table_valid, mtv);
    chk("cfg_err", cfg_err, merr);
    chk("cfg_ready", cfg_ready, rst_n);
  endtask

  task automatic beat(input logic [15:0] d, input logic last);
    cfg_valid = 1; cfg_data = d; cfg_last = last;
    step();
    cfg_valid = 0; cfg_last = 0;
  endtask

  task automatic beats(input int n, input logic [15:0] d);
    for (int k = 0; k < n; k++) beat(d, 1'b0);
  endtask

  task automatic load_all(input logic [15:0] d, input int sk, input logic [15:0] sd);
    for (int k = 0; k < NB; k++) beat((k == sk) ? sd : d, k == NB - 1);
  endtask

  task automatic lookup(input logic [7:0] a);
    in_valid = 1; M0 = a;
    step();
    in_valid = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{8'd48,  1'b1};
    vecs[1] = '{8'd47,  1'b0};
    vecs[2] = '{8'd49,  1'b0};
    vecs[3] = '{8'd0,   1'b0};
    vecs[4] = '{8'd63,  1'b0};
    vecs[5] = '{8'd255, 1'b0};

    // Reset state
    step(); step();
    chk("rst table_valid", table_valid, 0);
    chk("rst cfg_err", cfg_err, 0);
    chk("rst out_valid", out_valid, 0);
    chk("rst M1", M1, 0);
    chk("rst cfg_ready", cfg_ready, 0);
    rst_n = 1;
    step();
    chk("post-rst cfg_ready", cfg_ready, 1);

    // One-hot entry 48 (beat 3, bit 0)
    load_all(16'h0000, 3, 16'h0001);
    chk("load table_valid", table_valid, 1);
    foreach (vecs[i]) begin
      lookup(vecs[i].m0);
      chk("vec out_valid", out_valid, 1);
      chk("vec M1", M1, vecs[i].exp_m1);
    end

    // Early last on beat 5
    beats(5, 16'h1234);
    beat(16'h1234, 1'b1);
    chk("early-last cfg_err", cfg_err, 1);
    chk("early-last table_valid", table_valid, 0);
    lookup(8'd0);
    chk("early-last out_valid", out_valid, 0);
    err_clr = 1; step(); err_clr = 0;
    chk("err_clr", cfg_err, 0);

    // Missing last on beat 15, then a clean load keeps the sticky error
    beats(16, 16'h5555);
    chk("no-last cfg_err", cfg_err, 1);
    chk("no-last table_valid", table_valid, 0);
    load_all(16'hA5A5, -1, 16'h0);
    chk("reload table_valid", table_valid, 1);
    chk("sticky cfg_err", cfg_err, 1);
    lookup(8'd0);  chk("A5 M1[0]", M1, 1);
    lookup(8'd1);  chk("A5 M1[1]", M1, 0);
    err_clr = 1; step(); err_clr = 0;
    chk("err_clr 2", cfg_err, 0);

    // Reset mid-load abandons the partial table
    beats(10, 16'h0F0F);
    rst_n = 0; step(); rst_n = 1;
    chk("mid-rst table_valid", table_valid, 0);
    step();
    load_all(16'hFFFF, -1, 16'h0);
    chk("ffff table_valid", table_valid, 1);
    lookup(8'd0);   chk("ffff M1@0", M1, 1);
    lookup(8'd128); chk("ffff M1@128", M1, 1);
    lookup(8'd255); chk("ffff M1@255", M1, 1);

    // Reload with zeros; lookup alongside beat 0 reads the old table
    in_valid = 1; M0 = 8'd7;
    beat(16'h0000, 1'b0);
    in_valid = 0;
    chk("reload-b0 out_valid", out_valid, 1);
    chk("reload-b0 M1", M1, 1);
    chk("reload-b0 table_valid", table_valid, 0);
    for (int k = 1; k < NB; k++) beat(16'h0000, k == NB - 1);
    lookup(8'd7);
    chk("zero M1@7", M1, 0);

    // in_valid held across the final beat
    beats(15, 16'h00FF);
    in_valid = 1; M0 = 8'd3;
    beat(16'h00FF, 1'b1);
    chk("inflight out_valid", out_valid, 0);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("held out_valid", out_valid, 1);
      chk("held M1", M1, 1);
    end
    in_valid = 0;

    // Randomized traffic with occasional framing errors and resets
    for (int c = 0; c < 2000; c++) begin
      rst_n     = ($urandom_range(0, 199) != 0);
      cfg_valid = $urandom_range(0, 1) != 0;
      cfg_data  = 16'($urandom);
      cfg_last  = (mframe == NB - 1) ^ ($urandom_range(0, 39) == 0);
      in_valid  = $urandom_range(0, 1) != 0;
      M0        = 8'($urandom);
      err_clr   = ($urandom_range(0, 15) == 0);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lut_neuron_loader.md
LUT_NEURON_LOADER -- requirements
Module: lut_neuron_loader

Interface
REQ-001 Parameter IN_BITS, default 8: neuron input width; the table holds 2^IN_BITS entries.
REQ-002 Parameter OUT_BITS, default 1: width of each table entry and of the lookup result.
REQ-003 Parameter CFG_W, default 16: config beat width; SHALL be a multiple of OUT_BITS and SHALL divide 2^IN_BITS*OUT_BITS.
REQ-004 clk  in  1  single clock; all logic on its rising edge.
REQ-005 rst_n  in  1  reset, synchronous and active-low.
REQ-006 cfg_valid  in  1  config beat offered.
REQ-007 cfg_ready  out  1  config beat accepted when cfg_valid & cfg_ready.
REQ-008 cfg_data  in  CFG_W  packed truth-table entries.
REQ-009 cfg_last  in  1  marks the final beat of a table.
REQ-010 err_clr  in  1  clears cfg_err.
REQ-011 M0  in  IN_BITS  lookup address (neuron input).
REQ-012 in_valid  in  1  lookup request.
REQ-013 M1  out  OUT_BITS  lookup result (neuron output).
REQ-014 out_valid  out  1  M1 valid this cycle.
REQ-015 table_valid  out  1  complete table loaded.
REQ-016 cfg_err  out  1  sticky framing error.

Function
REQ-017 Derived constants: EPB = CFG_W/OUT_BITS entries per beat; NBEATS = 2^IN_BITS/EPB (16 at defaults).
REQ-018 Beat k, k = 0..NBEATS-1, SHALL write entry k*EPB+j from cfg_data[j*OUT_BITS +: OUT_BITS] for every j < EPB.
REQ-019 The state machine SHALL have three states: EMPTY, LOAD and ACTIVE.
REQ-020 cfg_ready SHALL be 1 in all three states; the block never back-pressures.
REQ-021 EMPTY or ACTIVE, accepted beat with cfg_last=0 -> write beat 0, set beat count to 1, clear table_valid on the next edge, go to LOAD.
REQ-022 LOAD, accepted beat with count < NBEATS-1 and cfg_last=0 -> write beat, increment count.
REQ-023 LOAD, accepted beat with count = NBEATS-1 and cfg_last=1 -> write beat, count to 0, table_valid to 1, go to ACTIVE.
REQ-024 Framing error: cfg_last=1 before the final beat, cfg_last=0 on the final beat, or cfg_last=1 on a first beat while NBEATS>1.
REQ-025 On a framing error the beat SHALL be discarded, cfg_err set to 1, count cleared, table_valid held at 0, and the state SHALL go to EMPTY.
REQ-026 cfg_err SHALL be cleared only by reset or by err_clr; if err_clr and a new error occur in the same cycle, the error wins.
REQ-027 Lookup latency is 1 cycle: M1 SHALL be the registered table[M0], and out_valid the registered (in_valid & table_valid).
REQ-028 In-flight lookup: a lookup in the same cycle as the final accepted beat sees the old table_valid (0), so out_valid=0 next cycle.
REQ-029 Reload: a lookup in the same cycle as a reload's first beat is served from the pre-write table with table_valid still 1.
REQ-030 When out_valid=0, M1 SHALL hold its previous value.
REQ-031 Table storage SHALL be distributed RAM with no reset; its contents are undefined until the first complete load.

Reset
REQ-032 While rst_n=0 at a clock edge, the outputs SHALL take: state EMPTY, count 0, table_valid 0, cfg_err 0, out_valid 0, M1 0.
REQ-033 Reset during LOAD SHALL abandon the partial table; table_valid stays 0 until a full new load completes.
REQ-034 cfg_ready SHALL be 0 while rst_n=0 and 1 from the first cycle after release.

Verification
REQ-035 Load 16 beats, beat 3 = 0x0001 and all others 0x0000, last on beat 15 -> table_valid=1; one cycle after each request: M0=48 gives M1=1, M0=47 gives 0, M0=49 gives 0.
REQ-036 cfg_last=1 on beat 5 -> cfg_err=1, table_valid=0, then M0=0 with in_valid=1 gives out_valid=0; err_clr pulse -> cfg_err=0.
REQ-037 Beat 15 with cfg_last=0 -> cfg_err=1, state EMPTY; a following correct 16-beat load -> table_valid=1 and cfg_err still 1 until err_clr.
REQ-038 rst_n=0 for 1 cycle after beat 9 -> table_valid=0, count 0; a fresh 16-beat load of 0xFFFF -> M1=1 for M0 = 0, 128 and 255.
REQ-039 Table loaded with all 0xFFFF, then reload with all 0x0000 -> table_valid=0 from the cycle after beat 0; M0=7 after beat 15 gives M1=0.
REQ-040 in_valid held high across the cycle of the final beat -> out_valid=0 on the next cycle, then 1 on every cycle after that.
